// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage: data widths, the decode NOP
// and the instruction-buffer entry layout.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;
    logic [31:0]     instr;
    logic            returned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer: allocation (tail), response write (oldest
// non-returned entry) and decode pop (head), each with its own pointer.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic [XLEN-1:0] alloc_pc_plus_4,
  input  logic            rsp_wr,
  input  logic [31:0]     rsp_data,
  input  logic            pop,
  output logic            validD,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus_4D
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     entries [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    rptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop clears the returned bit so a wrapped head never shows a stale entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i].returned <= 1'b0;
    end else begin
      if (pop) begin
        entries[head].returned <= 1'b0;
        head                   <= next_ptr(head);
      end
      if (alloc) begin
        entries[tail].pc        <= alloc_pc;
        entries[tail].pc_plus_4 <= alloc_pc_plus_4;
        entries[tail].returned  <= 1'b0;
        tail                    <= next_ptr(tail);
      end
      if (rsp_wr) begin
        entries[rptr].instr    <= rsp_data;
        entries[rptr].returned <= 1'b1;
        rptr                   <= next_ptr(rptr);
      end
    end
  end

  assign validD     = entries[head].returned;
  assign instrD     = validD ? entries[head].instr : NOP_WORD;
  assign pcD        = entries[head].pc;
  assign pc_plus_4D = entries[head].pc_plus_4;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: request gating against buffer space and in-flight limit,
// in-flight/drop bookkeeping across redirects, and the decode-facing buffer.
module fetch_stage #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [fetch_stage_pkg::XLEN-1:0] pc_in,
  input  logic [fetch_stage_pkg::XLEN-1:0] pc_plus_4_in,
  input  logic                            flush,
  input  logic                            stallD,
  output logic                            imem_req_valid,
  output logic [fetch_stage_pkg::XLEN-1:0] imem_req_addr,
  input  logic                            imem_req_ready,
  input  logic                            imem_rsp_valid,
  input  logic [31:0]                     imem_rsp_data,
  output logic                            stallF,
  output logic                            validD,
  output logic [31:0]                     instrD,
  output logic [fetch_stage_pkg::XLEN-1:0] pcD,
  output logic [fetch_stage_pkg::XLEN-1:0] pc_plus_4D
);

  import fetch_stage_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic          accept;
  logic          pop;
  logic          rsp_live;

  assign imem_req_valid = rst && !flush && (count < CW'(DEPTH)) && (outst < CW'(DEPTH));
  assign imem_req_addr  = pc_in;
  assign accept         = imem_req_valid && imem_req_ready;
  assign stallF         = !(rst && (accept || flush));
  assign pop            = validD && !stallD && !flush;
  assign rsp_live       = imem_rsp_valid && !flush && (drop == '0);

  // On redirect every request still in flight becomes dead, except one whose
  // response lands in the flush cycle itself (it is consumed right here).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      outst <= '0;
      drop  <= '0;
    end else if (flush) begin
      count <= '0;
      outst <= outst - CW'(imem_rsp_valid);
      drop  <= outst - CW'(imem_rsp_valid);
    end else begin
      count <= count + CW'(accept) - CW'(pop);
      outst <= outst + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP_INSTR)
  ) u_buffer (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .alloc           (accept),
    .alloc_pc        (pc_in),
    .alloc_pc_plus_4 (pc_plus_4_in),
    .rsp_wr          (rsp_live),
    .rsp_data        (imem_rsp_data),
    .pop             (pop),
    .validD          (validD),
    .instrD          (instrD),
    .pcD             (pcD),
    .pc_plus_4D      (pc_plus_4D)
  );

endmodule
